// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: op codes, default widths and FSM states.
package alu_pkg;

  localparam int ALU_N = 2;
  localparam int ALU_M = 4;

  localparam logic [1:0] ALU_SUB  = 2'b00;
  localparam logic [1:0] ALU_COMP = 2'b01;
  localparam logic [1:0] ALU_SUM  = 2'b10;
  localparam logic [1:0] ALU_CONV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response buses of the arbiter; slave is the arbiter side, master the environment.
interface alu_req_arbiter_if
  import alu_pkg::*;
#(
  parameter int N = ALU_N,
  parameter int M = ALU_M
);

  logic [1:0]     i_req_valid;
  logic [2*N-1:0] i_req_op;
  logic [2*M-1:0] i_req_a;
  logic [2*M-1:0] i_req_b;
  logic [1:0]     o_req_ready;

  logic [N-1:0]   o_alu_op;
  logic [M-1:0]   o_alu_a;
  logic [M-1:0]   o_alu_b;
  logic [M-1:0]   i_alu_result;
  logic [3:0]     i_alu_status;

  logic           o_rsp_valid;
  logic           o_rsp_id;
  logic [M-1:0]   o_rsp_result;
  logic [3:0]     o_rsp_status;
  logic           i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_op, i_req_a, i_req_b,
    input  i_alu_result, i_alu_status, i_rsp_ready,
    output o_req_ready, o_alu_op, o_alu_a, o_alu_b,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status
  );

  modport master (
    output i_req_valid, i_req_op, i_req_a, i_req_b,
    output i_alu_result, i_alu_status, i_rsp_ready,
    input  o_req_ready, o_alu_op, o_alu_a, o_alu_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status
  );

endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way grant: round-robin pointer by default, fixed priority (requester 0) when
// ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic       o_grant_valid,
  output logic       o_grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{i_clk, i_reset, i_accept};

  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = ~i_valid[0];
  end

`else

  logic ptr_q, ptr_d;

  // The favoured requester wins if valid; otherwise the other one is served so an idle side never stalls.
  always_comb begin
    o_grant_valid = |i_valid;
    o_grant_id    = i_valid[ptr_q] ? ptr_q : ~ptr_q;
    ptr_d         = i_accept ? ~o_grant_id : ptr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between two valid/ready requesters, one operation at a time.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int N       = ALU_N,
  parameter int M       = ALU_M,
  parameter int ALU_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  alu_req_arbiter_if.slave bus,
  output logic             o_busy
);

  localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  alu_op_q, alu_op_d;
  logic [M-1:0]  alu_a_q, alu_a_d;
  logic [M-1:0]  alu_b_q, alu_b_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_id_q, rsp_id_d;
  logic [M-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_status_q, rsp_status_d;

  logic          grant_valid;
  logic          grant_id;
  logic          accept;
  logic          wait_done;

  rr_arb2 u_arb (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_valid       (bus.i_req_valid),
    .i_accept      (accept),
    .o_grant_valid (grant_valid),
    .o_grant_id    (grant_id)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // WAIT runs ALU_LAT cycles: the counter is loaded in ISSUE and WAIT ends when it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        if (rsp_valid_q && bus.i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept          = (state_q == IDLE) && grant_valid;
    wait_done       = (state_q == WAIT) && (cnt_q == '0);
    bus.o_req_ready = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    o_busy          = (state_q != IDLE);

    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;

    if (accept) begin
      alu_op_d = grant_id ? bus.i_req_op[N +: N] : bus.i_req_op[0 +: N];
      alu_a_d  = grant_id ? bus.i_req_a[M +: M]  : bus.i_req_a[0 +: M];
      alu_b_d  = grant_id ? bus.i_req_b[M +: M]  : bus.i_req_b[0 +: M];
      rsp_id_d = grant_id;
    end
    if (wait_done) begin
      rsp_result_d = bus.i_alu_result;
      rsp_status_d = bus.i_alu_status;
      rsp_valid_d  = 1'b1;
    end
    if ((state_q == RESP) && rsp_valid_q && bus.i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_alu_a      = alu_a_q;
  assign bus.o_alu_b      = alu_b_q;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_rsp_result = rsp_result_q;
  assign bus.o_rsp_status = rsp_status_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: one ALU_LAT=1 instance with a registered ALU model and
// one ALU_LAT=3 instance with a three-stage ALU model.
`timescale 1ns/1ps
module tb_alu_req_arbiter;
  import alu_pkg::*;

  logic i_clk = 1'b0;
  logic i_reset;
  logic busy1, busy3;
  int   vectorCount = 0;
  int   failCount   = 0;

  alu_req_arbiter_if #(.N(2), .M(4)) bus1 ();
  alu_req_arbiter_if #(.N(2), .M(4)) bus3 ();

  alu_req_arbiter #(.N(2), .M(4), .ALU_LAT(1)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus1),
    .o_busy  (busy1)
  );

  alu_req_arbiter #(.N(2), .M(4), .ALU_LAT(3)) dut3 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus3),
    .o_busy  (busy3)
  );

  always #5 i_clk = ~i_clk;

  // ALU reference: COMP is A>B, CONV is binary-to-Gray; status is {msb, zero, op}.
  function automatic logic [7:0] aluModel(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      ALU_SUB:  r = a - b;
      ALU_COMP: r = (a > b) ? 4'd1 : 4'd0;
      ALU_SUM:  r = a + b;
      default:  r = a ^ (a >> 1);
    endcase
    return {r[3], (r == 4'd0), op, r};
  endfunction

  logic [7:0] alu1Q;
  logic [7:0] pipe1, pipe2, pipe3;

  always @(posedge i_clk) alu1Q <= aluModel(bus1.o_alu_op, bus1.o_alu_a, bus1.o_alu_b);
  assign {bus1.i_alu_status, bus1.i_alu_result} = alu1Q;

  always @(posedge i_clk) begin
    pipe1 <= aluModel(bus3.o_alu_op, bus3.o_alu_a, bus3.o_alu_b);
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign {bus3.i_alu_status, bus3.i_alu_result} = pipe3;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [3:0] ops, input logic [7:0] as,
                               input logic [7:0] bs, input logic rspReady);
    bus1.i_req_valid = valid;
    bus1.i_req_op    = ops;
    bus1.i_req_a     = as;
    bus1.i_req_b     = bs;
    bus1.i_rsp_ready = rspReady;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One isolated operation from requester k, checked cycle by cycle from T to T+4.
  task automatic singleOp(input logic k, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] expResult, input string name);
    logic [7:0] m;
    m = aluModel(op, a, b);
    if (k) applyStimulus(2'b10, {op, 2'b00}, {a, 4'h0}, {b, 4'h0}, 1'b1);
    else   applyStimulus(2'b01, {2'b00, op}, {4'h0, a}, {4'h0, b}, 1'b1);
    #1;
    checkOutput({name, " ready"}, bus1.o_req_ready, k ? 2'b10 : 2'b01);
    checkOutput({name, " idle busy"}, busy1, 1'b0);
    tick();
    applyStimulus(2'b00, 4'h0, 8'h00, 8'h00, 1'b1);
    #1;
    checkOutput({name, " issue busy"}, busy1, 1'b1);
    checkOutput({name, " issue ready"}, bus1.o_req_ready, 2'b00);
    checkOutput({name, " alu op"}, bus1.o_alu_op, op);
    checkOutput({name, " alu a"}, bus1.o_alu_a, a);
    checkOutput({name, " alu b"}, bus1.o_alu_b, b);
    tick();
    checkOutput({name, " wait busy"}, busy1, 1'b1);
    checkOutput({name, " wait rsp_valid"}, bus1.o_rsp_valid, 1'b0);
    tick();
    checkOutput({name, " resp busy"}, busy1, 1'b1);
    checkOutput({name, " rsp_valid"}, bus1.o_rsp_valid, 1'b1);
    checkOutput({name, " rsp_id"}, bus1.o_rsp_id, k);
    checkOutput({name, " rsp_result"}, bus1.o_rsp_result, expResult);
    checkOutput({name, " rsp_status"}, bus1.o_rsp_status, m[7:4]);
    tick();
    checkOutput({name, " done rsp_valid"}, bus1.o_rsp_valid, 1'b0);
    checkOutput({name, " done busy"}, busy1, 1'b0);
  endtask

  // Both requesters: req0 issues SUM (1+i)+2, req1 issues SUB (9+j)-4, while each has ops left.
  task automatic driveBoth(input int i0, input int i1);
    logic [3:0] a0, a1;
    a0 = 4'(1 + i0);
    a1 = 4'(9 + i1);
    applyStimulus({i1 < 4, i0 < 4}, {ALU_SUB, ALU_SUM}, {a1, a0}, {4'd4, 4'd2}, 1'b1);
  endtask

  initial begin
    logic [3:0] res0 [4];
    logic [3:0] res1 [4];
    logic [7:0] orderExp;
    logic [7:0] m;
    int         idx0, idx1;

    res0 = '{4'd3, 4'd4, 4'd5, 4'd6};
    res1 = '{4'd5, 4'd6, 4'd7, 4'd8};
`ifdef ALU_ARB_FIXED_PRIO_EN
    orderExp = 8'b1111_0000;
`else
    orderExp = 8'b1010_1010;
`endif

    i_reset = 1'b1;
    applyStimulus(2'b00, 4'h0, 8'h00, 8'h00, 1'b0);
    bus3.i_req_valid = 2'b00;
    bus3.i_req_op    = 4'h0;
    bus3.i_req_a     = 8'h00;
    bus3.i_req_b     = 8'h00;
    bus3.i_rsp_ready = 1'b1;
    tick();
    tick();
    checkOutput("reset busy", busy1, 1'b0);
    checkOutput("reset ready", bus1.o_req_ready, 2'b00);
    checkOutput("reset rsp_valid", bus1.o_rsp_valid, 1'b0);
    checkOutput("reset rsp_id", bus1.o_rsp_id, 1'b0);
    checkOutput("reset rsp_result", bus1.o_rsp_result, 4'h0);
    checkOutput("reset rsp_status", bus1.o_rsp_status, 4'h0);
    checkOutput("reset alu op", bus1.o_alu_op, 2'b00);
    checkOutput("reset alu a", bus1.o_alu_a, 4'h0);
    checkOutput("reset alu b", bus1.o_alu_b, 4'h0);
    checkOutput("reset busy3", busy3, 1'b0);
    i_reset = 1'b0;

    $display("[TB] single requester operations");
    singleOp(1'b0, ALU_COMP, 4'b1110, 4'b0011, 4'b0001, "req0 comp");
    singleOp(1'b1, ALU_CONV, 4'b1101, 4'b0000, 4'b1011, "req1 conv");

    $display("[TB] both requesters continuously valid");
    idx0 = 0;
    idx1 = 0;
    for (int n = 0; n < 8; n++) begin
      logic gid;
      int   opIdx;
      driveBoth(idx0, idx1);
      #1;
      gid = orderExp[n];
      checkOutput($sformatf("alt grant %0d", n), bus1.o_req_ready, gid ? 2'b10 : 2'b01);
      opIdx = gid ? idx1 : idx0;
      if (gid) idx1++;
      else     idx0++;
      tick();
      driveBoth(idx0, idx1);
      tick();
      tick();
      checkOutput($sformatf("alt rsp_valid %0d", n), bus1.o_rsp_valid, 1'b1);
      checkOutput($sformatf("alt rsp_id %0d", n), bus1.o_rsp_id, gid);
      checkOutput($sformatf("alt rsp_result %0d", n), bus1.o_rsp_result, gid ? res1[opIdx] : res0[opIdx]);
      tick();
    end
    checkOutput("alt drained busy", busy1, 1'b0);

    $display("[TB] response back-pressure");
    m = aluModel(ALU_SUB, 4'd7, 4'd2);
    applyStimulus(2'b01, {ALU_SUM, ALU_SUB}, {4'd3, 4'd7}, {4'd3, 4'd2}, 1'b0);
    #1;
    checkOutput("stall grant", bus1.o_req_ready, 2'b01);
    tick();
    applyStimulus(2'b10, {ALU_SUM, ALU_SUB}, {4'd3, 4'd7}, {4'd3, 4'd2}, 1'b0);
    tick();
    tick();
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("stall rsp_valid %0d", s), bus1.o_rsp_valid, 1'b1);
      checkOutput($sformatf("stall rsp_result %0d", s), bus1.o_rsp_result, 4'd5);
      checkOutput($sformatf("stall rsp_status %0d", s), bus1.o_rsp_status, m[7:4]);
      checkOutput($sformatf("stall rsp_id %0d", s), bus1.o_rsp_id, 1'b0);
      checkOutput($sformatf("stall ready %0d", s), bus1.o_req_ready, 2'b00);
      tick();
    end
    bus1.i_rsp_ready = 1'b1;
    #1;
    checkOutput("release rsp_valid", bus1.o_rsp_valid, 1'b1);
    tick();
    checkOutput("release cleared", bus1.o_rsp_valid, 1'b0);
    checkOutput("release idle", busy1, 1'b0);
    checkOutput("release next grant", bus1.o_req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 4'h0, 8'h00, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("req1 sum rsp_id", bus1.o_rsp_id, 1'b1);
    checkOutput("req1 sum rsp_result", bus1.o_rsp_result, 4'd6);
    tick();

    $display("[TB] reset during WAIT");
    applyStimulus(2'b11, {ALU_SUM, ALU_SUB}, {4'd1, 4'hA}, {4'd1, 4'd3}, 1'b1);
    #1;
    checkOutput("pre-reset grant", bus1.o_req_ready, 2'b01);
    tick();
    checkOutput("pre-reset alu a", bus1.o_alu_a, 4'hA);
    tick();
    i_reset = 1'b1;
    #1;
    checkOutput("pre-reset wait busy", busy1, 1'b1);
    tick();
    i_reset = 1'b0;
    #1;
    checkOutput("post-reset busy", busy1, 1'b0);
    checkOutput("post-reset rsp_valid", bus1.o_rsp_valid, 1'b0);
    checkOutput("post-reset rsp_result", bus1.o_rsp_result, 4'h0);
    checkOutput("post-reset rsp_status", bus1.o_rsp_status, 4'h0);
    checkOutput("post-reset alu op", bus1.o_alu_op, 2'b00);
    checkOutput("post-reset alu a", bus1.o_alu_a, 4'h0);
    checkOutput("post-reset regrant", bus1.o_req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 4'h0, 8'h00, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("regrant rsp_valid", bus1.o_rsp_valid, 1'b1);
    checkOutput("regrant rsp_id", bus1.o_rsp_id, 1'b0);
    checkOutput("regrant rsp_result", bus1.o_rsp_result, 4'd7);
    tick();

    $display("[TB] ALU_LAT=3 instance");
    m = aluModel(ALU_SUM, 4'd5, 4'd6);
    bus3.i_req_valid = 2'b01;
    bus3.i_req_op    = {2'b00, ALU_SUM};
    bus3.i_req_a     = {4'h0, 4'd5};
    bus3.i_req_b     = {4'h0, 4'd6};
    #1;
    checkOutput("lat3 grant", bus3.o_req_ready, 2'b01);
    tick();
    bus3.i_req_valid = 2'b00;
    for (int c = 1; c < 5; c++) begin
      checkOutput($sformatf("lat3 early rsp_valid T+%0d", c), bus3.o_rsp_valid, 1'b0);
      checkOutput($sformatf("lat3 busy T+%0d", c), busy3, 1'b1);
      tick();
    end
    checkOutput("lat3 rsp_valid T+5", bus3.o_rsp_valid, 1'b1);
    checkOutput("lat3 rsp_result", bus3.o_rsp_result, 4'b1011);
    checkOutput("lat3 rsp_status", bus3.o_rsp_status, m[7:4]);
    checkOutput("lat3 rsp_id", bus3.o_rsp_id, 1'b0);
    tick();
    checkOutput("lat3 done", bus3.o_rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one synchronous 4-bit arithmetic unit between two requesters using valid/ready handshakes. Arbitration is round-robin. The block latches the granted operation, drives the ALU operand/op bus, waits the ALU's fixed registered latency, captures result and status, and returns them tagged with the requester ID. It sits between the two command sources and the ALU instance and runs one operation at a time, non-pipelined.

Parameters:
N, 2, op-code width (matches ALU i_op)
M, 4, operand/result width (matches ALU i_arg_A/i_arg_B/o_result)
ALU_LAT, 1, ALU cycles from sampling operands to valid o_result/o_status; legal range >=1

Ports:
i_clk  input  1  single clock, all logic on posedge
i_reset  input  1  synchronous, active-high reset
i_req_valid  input  2  bit k: requester k presents an op
i_req_op  input  2*N  requester k op in [k*N +: N]
i_req_a  input  2*M  requester k operand A in [k*M +: M]
i_req_b  input  2*M  requester k operand B in [k*M +: M]
o_req_ready  output  2  bit k: requester k's op is accepted this cycle
o_alu_op  output  N  to ALU i_op
o_alu_a  output  M  to ALU i_arg_A
o_alu_b  output  M  to ALU i_arg_B
i_alu_result  input  M  from ALU o_result
i_alu_status  input  4  from ALU o_status
o_rsp_valid  output  1  response available
o_rsp_id  output  1  requester that owns the response
o_rsp_result  output  M  captured ALU result
o_rsp_status  output  4  captured ALU status
i_rsp_ready  input  1  consumer accepts response
o_busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock i_clk; reset i_reset is synchronous and active-high.
- States: IDLE, ISSUE, WAIT, RESP. 2-bit state register, plus wait counter sized to ALU_LAT.
- Reset: state IDLE. rr_ptr=0 (requester 0 favoured first). o_alu_op/a/b=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0, o_rsp_status=0, o_busy=0. Reset mid-operation abandons the in-flight op; no response is issued.
- IDLE: grant g = rr_ptr if i_req_valid[rr_ptr], else the other requester if it is valid. o_req_ready[g]=1 combinationally only in IDLE with a valid grant; the other bit is 0. o_req_ready is 0 in all other states.
- On the handshake edge: latch op/a/b of g into o_alu_*; set o_rsp_id=g; rr_ptr <= ~g; go to ISSUE.
- Requesters hold valid and payload stable until ready. The arbiter never drops a valid request.
- ISSUE: 1 cycle. o_alu_* are stable, and the ALU samples them at the closing edge. Load the wait counter with ALU_LAT-1. Go to WAIT.
- WAIT: ALU_LAT cycles. At the closing edge of the last WAIT cycle, capture i_alu_result and i_alu_status into o_rsp_result/o_rsp_status, set o_rsp_valid=1, and go to RESP.
- RESP: hold o_rsp_* stable while i_rsp_ready=0. On the edge where o_rsp_valid & i_rsp_ready: clear o_rsp_valid and go to IDLE. A new grant is possible in the next cycle.
- Latency with ALU_LAT=1: handshake edge at T; o_rsp_valid high from T+3. Peak throughput is one op per 4 cycles with i_rsp_ready tied high.
- o_alu_* hold their last issued values outside ISSUE. The ALU has no enable, so its output stays consistent.
- Both requests valid in IDLE: rr_ptr decides. Back-to-back requests from both alternate 0,1,0,1.
- Single requester continuously valid: it is served every turn. Round-robin never stalls on an idle requester.
- Ops are passed through unchanged, including codes the ALU leaves unimplemented. The controller does not validate op codes.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN: when defined, round-robin is replaced by fixed priority. Requester 0 always wins when both are valid, and rr_ptr is not implemented. When undefined, round-robin operates as described above.

Decomposition:
- Shared package alu_pkg holds:
  - op-code constants ALU_SUB=2'b00, ALU_COMP=2'b01, ALU_SUM=2'b10, ALU_CONV=2'b11;
  - the N and M defaults;
  - the typedef enum logic [1:0] for the arbiter states {IDLE, ISSUE, WAIT, RESP}.
- One natural sub-module is rr_arb2: a 2-way round-robin grant with pointer and fixed-priority option. It is combinational grant plus pointer register.

Test Plan:
- Reset then single req0: COMP, A=4'b1110, B=4'b0011, ALU attached. Expect ready[0] in IDLE; o_rsp_valid at T+3 with id=0, result=4'b0001.
- req1 alone: CONV, A=4'b1101. Expect o_rsp_id=1, o_rsp_result=4'b1011; o_busy high for 3 cycles then through RESP.
- Both valid continuously, i_rsp_ready=1, 4 ops each. Expect grant order 0,1,0,1,...; no starvation. With ALU_ARB_FIXED_PRIO_EN, all 4 req0 ops complete before any req1 op.
- i_rsp_ready held 0 for 5 cycles in RESP. Expect o_rsp_* stable, o_req_ready=0 throughout; release gives one accept and returns to IDLE.
- Assert i_reset in WAIT. Next cycle: state IDLE, o_rsp_valid=0, all outputs at reset values; the pending request is re-granted to requester 0 after reset deasserts.
- ALU_LAT=3 build with a delayed ALU model. Expect o_rsp_valid at T+5 with the correct captured value.
